// File: rtl/encoder_4_2_debounced_pkg.sv
// Shared types, sizes and the 4-to-2 priority encoder for encoder_4_2_debounced.
package encoder_pkg;

  localparam int unsigned N_IN                = 4;
  localparam int unsigned W_CODE              = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    LOCK    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  // Highest set bit wins; an all-zero vector maps to 0.
  function automatic logic [W_CODE-1:0] prio_enc4(input logic [N_IN-1:0] vec);
    logic [W_CODE-1:0] idx;
    idx = W_CODE'(0);
    if (vec[3])      idx = W_CODE'(3);
    else if (vec[2]) idx = W_CODE'(2);
    else if (vec[1]) idx = W_CODE'(1);
    return idx;
  endfunction

endpackage

// File: rtl/encoder_4_2_debounced_sync2.sv
// Two-flop synchronizer bank with asynchronous active-low reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/encoder_4_2_debounced.sv
// Synchronizes and debounces four request lines, then priority-encodes the
// accepted vector with a held valid and a one-cycle strobe per press.
module encoder_4_2_debounced
  import encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   req,
  output logic [W_CODE-1:0] code,
  output logic              valid,
  output logic              strobe,
  output logic              any_raw
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0]   w_s;
  state_e            r_state;
  logic [N_IN-1:0]   r_cap;
  logic [CNT_W-1:0]  r_cnt;
  logic [W_CODE-1:0] r_code;
  logic              r_valid;
  logic              r_strobe;
  logic              r_any_raw;

  sync2 #(.WIDTH(N_IN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req),
    .q     (w_s)
  );

  // Debounce FSM; the counter only advances below CNT_MAX so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cap     <= '0;
      r_cnt     <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_strobe  <= 1'b0;
      r_any_raw <= 1'b0;
    end else begin
      r_strobe  <= 1'b0;
      r_any_raw <= |w_s;
      case (r_state)
        IDLE: begin
          if (w_s != '0) begin
            r_cap   <= w_s;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_s != r_cap) begin
            if (w_s == '0) begin
              r_state <= IDLE;
            end else begin
              r_cap <= w_s;
              r_cnt <= '0;
            end
          end else if (r_cnt == CNT_MAX) begin
            r_state  <= LOCK;
            r_code   <= prio_enc4(r_cap);
            r_valid  <= 1'b1;
            r_strobe <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Any nonzero vector keeps the press alive; only all-zero starts release.
        LOCK: begin
          if (w_s == '0) begin
            r_cnt   <= '0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_s != '0) begin
            r_cnt   <= '0;
            r_state <= LOCK;
          end else if (r_cnt == CNT_MAX) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign code    = r_code;
  assign valid   = r_valid;
  assign strobe  = r_strobe;
  assign any_raw = r_any_raw;

endmodule

// File: tb/tb_encoder_4_2_debounced.sv
// Scoreboard bench: stimulus queues expected strobes and valid falls, a
// negedge monitor pops and compares them as the DUT produces them.
module tb_encoder_4_2_debounced;

  localparam int unsigned DC  = 8;
  localparam int unsigned LAT = DC + 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] code;
  logic       valid;
  logic       strobe;
  logic       any_raw;

  int total;
  int bad;
  int cyc;
  logic prev_valid;

  int         q_stb_cyc[$];
  logic [1:0] q_stb_code[$];
  int         q_fall_cyc[$];
  logic [1:0] q_fall_code[$];

  encoder_4_2_debounced #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .code    (code),
    .valid   (valid),
    .strobe  (strobe),
    .any_raw (any_raw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // req is driven at a negedge, so the next posedge is the first sampling edge.
  task automatic expect_strobe(input logic [1:0] c);
    q_stb_cyc.push_back(cyc + LAT);
    q_stb_code.push_back(c);
  endtask

  task automatic expect_fall(input logic [1:0] c);
    q_fall_cyc.push_back(cyc + LAT);
    q_fall_code.push_back(c);
  endtask

  // Monitor: every strobe and every valid fall must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (strobe) begin
        if (q_stb_cyc.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          check("strobe_cycle", cyc, q_stb_cyc.pop_front());
          check("strobe_code", int'(code), int'(q_stb_code.pop_front()));
        end
      end
      if (prev_valid && !valid) begin
        if (q_fall_cyc.size() == 0) begin
          check("unexpected_valid_fall", 1, 0);
        end else begin
          check("fall_cycle", cyc, q_fall_cyc.pop_front());
          check("fall_code_held", int'(code), int'(q_fall_code.pop_front()));
        end
      end
    end
    prev_valid = valid;
  end

  initial begin
    total = 0;
    bad = 0;
    prev_valid = 1'b0;
    rst_n = 1'b1;
    req = 4'b1111;
    #2 rst_n = 1'b0;

    // Reset with all requests held high.
    wait_cyc(3);
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_strobe", int'(strobe), 0);
    check("rst_any_raw", int'(any_raw), 0);
    rst_n = 1'b1;
    expect_strobe(2'd3);
    wait_cyc(15);
    check("lock_valid_3", int'(valid), 1);
    check("lock_any_raw", int'(any_raw), 1);
    req = 4'b0000;
    expect_fall(2'd3);
    wait_cyc(15);

    // Clean press.
    req = 4'b0100;
    expect_strobe(2'd2);
    wait_cyc(20);
    check("clean_valid", int'(valid), 1);
    check("clean_code", int'(code), 2);
    req = 4'b0000;
    expect_fall(2'd2);
    wait_cyc(15);
    check("clean_code_after_release", int'(code), 2);
    check("clean_valid_after_release", int'(valid), 0);

    // Bouncing contact: short bursts never reach the debounce count.
    for (int i = 0; i < 10; i++) begin
      req = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      wait_cyc(3);
    end
    check("bounce_no_valid", int'(valid), 0);
    req = 4'b0100;
    expect_strobe(2'd2);
    wait_cyc(20);
    req = 4'b0000;
    expect_fall(2'd2);
    wait_cyc(15);

    // Vector change during settling restarts the count.
    req = 4'b0001;
    wait_cyc(5);
    req = 4'b0011;
    expect_strobe(2'd1);
    wait_cyc(20);
    check("prio_code", int'(code), 1);

    // Short release glitch inside a press, then a different nonzero vector.
    req = 4'b0000;
    wait_cyc(4);
    req = 4'b0010;
    wait_cyc(15);
    check("glitch_valid", int'(valid), 1);
    check("glitch_code", int'(code), 1);
    req = 4'b1000;
    wait_cyc(15);
    check("lock_ignores_change", int'(code), 1);
    req = 4'b0000;
    expect_fall(2'd1);
    wait_cyc(15);

    // Asynchronous reset while settling.
    req = 4'b1000;
    wait_cyc(6);
    rst_n = 1'b0;
    #1;
    check("midrst_code", int'(code), 0);
    check("midrst_any_raw", int'(any_raw), 0);
    check("midrst_valid", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_strobe(2'd3);
    wait_cyc(15);
    check("midrst_relock_valid", int'(valid), 1);
    req = 4'b0000;
    expect_fall(2'd3);
    wait_cyc(15);

    check("pending_strobes", q_stb_cyc.size(), 0);
    check("pending_falls", q_fall_cyc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
